bmf_h_decoder_seq: RTL and testbench
====================================

Name: bmf_h_decoder_seq

Overview:
- Streaming decompressor for Boolean-matrix-factorized approximate circuits.
- Consumes K-bit latent vectors `k` (produced by a compressor stage) and emits M-bit outputs `y`.
- Each output bit is a Boolean product with a programmable basis matrix H (K rows × M columns): `y[m] = OR over i of (k[i] AND H[i][m])`, or XOR over i in GF(2) mode.
- Sits behind the compressor in the approximation evaluation datapath.
- H is runtime-loadable through a shadow bank, so factorizations can be swapped without resynthesis.

Parameters:
- K, 6, latent width (rows of H).
- M, 7, output width (columns of H).
- CNT_W, 16, width of the decoded-vector counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  write one row of the shadow H bank.
- cfg_row  in  $clog2(K)  row index for cfg_we.
- cfg_data  in  M  row contents.
- cfg_xor  in  1  semiring select latched on commit: 0 = OR, 1 = XOR.
- cfg_commit  in  1  request to transfer shadow bank to active bank.
- cfg_busy  out  1  high while a commit is pending (state DRAIN).
- cfg_err  out  1  sticky flag: a cfg_we had cfg_row ≥ K.
- in_valid  in  1  latent vector valid.
- in_ready  out  1  decoder can accept a vector.
- in_k  in  K  latent vector.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts.
- out_y  out  M  decoded output.
- dec_count  out  CNT_W  saturating count of accepted input vectors.

Behaviour:
- Reset is synchronous and active-high on rst, single clock clk.
- Reset values:
  - state = UNCFG.
  - active H = 0, shadow H = 0, xor_mode = 0.
  - out_valid = 0, out_y = 0, in_ready = 0.
  - cfg_busy = 0, cfg_err = 0, dec_count = 0.
- FSM states: UNCFG, RUN, DRAIN, COPY.
  - UNCFG: in_ready = 0. cfg_commit → COPY.
  - RUN: in_ready = !out_valid || out_ready. cfg_commit → DRAIN.
  - DRAIN: in_ready = 0, cfg_busy = 1. When out_valid = 0, or (out_valid && out_ready) this cycle → COPY.
  - COPY: one cycle. active H ← shadow H, xor_mode ← value of cfg_xor captured at the commit request. cfg_busy = 1, in_ready = 0. Next state RUN.
- cfg_xor is sampled in the cycle cfg_commit is seen (held in a pending register). A further cfg_commit during DRAIN/COPY is ignored.
- Shadow writes:
  - cfg_we is accepted in every state, including DRAIN and COPY.
  - A write in the COPY cycle goes to shadow after the copy, i.e. it does not affect the active bank.
  - cfg_row ≥ K: write dropped and cfg_err set. cfg_err clears only on rst.
- Datapath: a single output register; latency 1 cycle from in handshake to out_valid.
  - Input handshake = in_valid && in_ready. On it, out_y ← f(in_k, active H, xor_mode) and out_valid ← 1.
  - out_valid && out_ready with no new handshake: out_valid ← 0 and out_y holds its last value.
  - Handshake and output drain in the same cycle: new data replaces old, out_valid stays 1. Full throughput, one vector per cycle.
  - out_y stays stable while out_valid && !out_ready.
  - in_valid may drop without a handshake. in_k is sampled only on handshake.
- Decoded-vector counter: dec_count increments on each input handshake and saturates at 2^CNT_W − 1 (no wrap).
- Boundary cases:
  - in_k = 0 → out_y = 0 in both modes.
  - Active H all zero (e.g. commit with no writes) → out_y = 0.
  - rst mid-stream: any pending output is discarded (out_valid = 0), both H banks clear, state returns to UNCFG.

Decomposition:
- Package bmf_pkg:
  - state enum (UNCFG, RUN, DRAIN, COPY).
  - default K/M localparams.
  - function `bool_mat_vec(k, H, xor_mode)` returning M bits.
- Sub-module bmf_h_bank: shadow plus active register arrays, the write port, the copy strobe, and cfg_err.
- FSM, handshake and counter stay in the top module.

Test Plan:
- Load rows 0..5 = 7'b0000010, 7'b0000101, 7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000; commit with cfg_xor = 0; send in_k = 6'b000010. Required: out_y = 7'b0000101 one cycle after the handshake. Then in_k = 6'b100001 → out_y = 7'b1000010.
- XOR mode: rows 0 and 1 both = 7'b0000011, commit with cfg_xor = 1, in_k = 6'b000011. Required: out_y = 7'b0000000. Same stimulus in OR mode → 7'b0000011.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1. Required: in_ready = 0 after the first accept, out_y stable, dec_count = 1. Release out_ready: back-to-back vectors at 1 per cycle.
- Commit while out_valid = 1 and out_ready = 0:
  - Required: cfg_busy = 1 and in_ready = 0 until out_ready pulses.
  - Required: exactly one COPY cycle, then the new H is applied to the next vector.
  - Required: the old result is delivered decoded with the old H.
- cfg_we with cfg_row = 6 (K = 6). Required: cfg_err = 1 and the shadow bank is unchanged; after 1000 accepted vectors, dec_count = 1000.
- Assert rst with out_valid = 1 mid-stream. Required next cycle: out_valid = 0, in_ready = 0, dec_count = 0, and a subsequent commit with no writes yields out_y = 0 for in_k = 6'b111111.

Source files
------------

// File: rtl/bmf_pkg.sv
// Shared types and the Boolean matrix-vector product for the BMF H decoder.
// The product works on padded maximum-size operands so any K/M up to the maxima can reuse it.
package bmf_pkg;

   localparam int unsigned BMF_K    = 6;
   localparam int unsigned BMF_M    = 7;
   localparam int unsigned BMF_KMAX = 32;
   localparam int unsigned BMF_MMAX = 32;

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      COPY  = 2'd3
   } bmf_state_e;

   typedef logic [BMF_KMAX-1:0][BMF_MMAX-1:0] bmf_hmat_t;

   // y[m] = OR_i (k[i] & H[i][m]), or XOR_i of the same terms in GF(2) mode
   function automatic logic [BMF_MMAX-1:0] bool_mat_vec(
      input logic [BMF_KMAX-1:0] k,
      input bmf_hmat_t           h,
      input logic                xor_mode
   );
      logic [BMF_MMAX-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < BMF_KMAX; i++) begin
         if (k[i]) begin
            acc = xor_mode ? (acc ^ h[i]) : (acc | h[i]);
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/bmf_h_bank.sv
// Shadow and active H register banks with row write port, copy strobe and sticky range error.
// A write landing in the copy cycle updates only the shadow; active takes the pre-write shadow.
module bmf_h_bank
   import bmf_pkg::*;
#(
   parameter  int unsigned K  = BMF_K,
   parameter  int unsigned M  = BMF_M,
   localparam int unsigned RW = (K > 1) ? $clog2(K) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_we,
   input  logic [RW-1:0]       i_row,
   input  logic [M-1:0]        i_data,
   input  logic                i_copy,
   output logic [K-1:0][M-1:0] o_active,
   output logic                o_err
);

   logic [K-1:0][M-1:0] r_shadow;
   logic [K-1:0][M-1:0] r_active;
   logic                r_err;
   logic                w_row_ok;

   assign w_row_ok = (32'(i_row) < K);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
         r_active <= '0;
         r_err    <= 1'b0;
      end else begin
         if (i_copy) begin
            r_active <= r_shadow;
         end
         if (i_we) begin
            if (w_row_ok) begin
               r_shadow[i_row] <= i_data;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign o_active = r_active;
   assign o_err    = r_err;

endmodule

// File: rtl/bmf_h_decoder_seq.sv
// Streaming BMF decompressor: decodes K-bit latents through a runtime-loadable H into M-bit outputs.
// Commits drain the single-entry output register before the one-cycle bank copy.
module bmf_h_decoder_seq
   import bmf_pkg::*;
#(
   parameter  int unsigned K     = BMF_K,
   parameter  int unsigned M     = BMF_M,
   parameter  int unsigned CNT_W = 16,
   localparam int unsigned RW    = (K > 1) ? $clog2(K) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [RW-1:0]    cfg_row,
   input  logic [M-1:0]     cfg_data,
   input  logic             cfg_xor,
   input  logic             cfg_commit,
   output logic             cfg_busy,
   output logic             cfg_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [K-1:0]     in_k,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [M-1:0]     out_y,
   output logic [CNT_W-1:0] dec_count
);

   bmf_state_e          r_state;
   bmf_state_e          w_state_nxt;
   logic                r_xor_pend;
   logic                r_xor_mode;
   logic                r_out_valid;
   logic [M-1:0]        r_out_y;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_in_ready;
   logic                w_busy;
   logic                w_copy;
   logic                w_capture;
   logic                w_hs;
   logic [K-1:0][M-1:0] w_active;
   bmf_hmat_t           w_h_pad;

   bmf_h_bank #(
      .K (K),
      .M (M)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .i_we     (cfg_we),
      .i_row    (cfg_row),
      .i_data   (cfg_data),
      .i_copy   (w_copy),
      .o_active (w_active),
      .o_err    (cfg_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= UNCFG;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, handshake gating and commit control
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_busy      = 1'b0;
      w_copy      = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         UNCFG: begin
            if (cfg_commit) begin
               w_capture   = 1'b1;
               w_state_nxt = COPY;
            end
         end
         RUN: begin
            w_in_ready = !r_out_valid || out_ready;
            if (cfg_commit) begin
               w_capture   = 1'b1;
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            w_busy = 1'b1;
            if (!r_out_valid || out_ready) begin
               w_state_nxt = COPY;
            end
         end
         COPY: begin
            w_busy      = 1'b1;
            w_copy      = 1'b1;
            w_state_nxt = RUN;
         end
         default: w_state_nxt = UNCFG;
      endcase
   end

   assign w_hs = in_valid && w_in_ready;

   always_comb begin
      w_h_pad = '0;
      for (int unsigned i = 0; i < K; i++) begin
         w_h_pad[i] = BMF_MMAX'(w_active[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_xor_pend <= 1'b0;
         r_xor_mode <= 1'b0;
      end else begin
         if (w_capture) begin
            r_xor_pend <= cfg_xor;
         end
         if (w_copy) begin
            r_xor_mode <= r_xor_pend;
         end
      end
   end

   // Single output register; a new handshake overwrites a result draining in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_y     <= '0;
      end else if (w_hs) begin
         r_out_valid <= 1'b1;
         r_out_y     <= M'(bool_mat_vec(BMF_KMAX'(in_k), w_h_pad, r_xor_mode));
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_hs && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = w_in_ready;
   assign cfg_busy  = w_busy;
   assign out_valid = r_out_valid;
   assign out_y     = r_out_y;
   assign dec_count = r_cnt;

endmodule

// File: tb/tb_bmf_h_decoder_seq.sv
// Directed self-checking bench for bmf_h_decoder_seq.
module tb_bmf_h_decoder_seq;

   localparam int unsigned K     = 6;
   localparam int unsigned M     = 7;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [2:0]       cfg_row;
   logic [M-1:0]     cfg_data;
   logic             cfg_xor;
   logic             cfg_commit;
   logic             cfg_busy;
   logic             cfg_err;
   logic             in_valid;
   logic             in_ready;
   logic [K-1:0]     in_k;
   logic             out_valid;
   logic             out_ready;
   logic [M-1:0]     out_y;
   logic [CNT_W-1:0] dec_count;

   int n_tot = 0;
   int n_bad = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   bmf_h_decoder_seq #(
      .K     (K),
      .M     (M),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_row    (cfg_row),
      .cfg_data   (cfg_data),
      .cfg_xor    (cfg_xor),
      .cfg_commit (cfg_commit),
      .cfg_busy   (cfg_busy),
      .cfg_err    (cfg_err),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_k       (in_k),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .dec_count  (dec_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] row, input logic [M-1:0] data);
      cfg_we   = 1'b1;
      cfg_row  = row;
      cfg_data = data;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic commit(input logic x);
      int n;
      cfg_commit = 1'b1;
      cfg_xor    = x;
      step();
      cfg_commit = 1'b0;
      cfg_xor    = ~x;
      n = 0;
      while (cfg_busy && n < 20) begin
         step();
         n++;
      end
      n_tot++;
      if (cfg_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL commit_timeout: cfg_busy=%b want 0", cfg_busy);
      end
   endtask

   task automatic push(input logic [K-1:0] k);
      int n;
      in_k      = k;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      n_tot++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL push_timeout: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      exp_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_tot += 6;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (out_y !== 7'b0) begin n_bad++; $display("FAIL rst_out_y: got %b want 0", out_y); end
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_busy: got %b want 0", cfg_busy); end
      if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
      if (dec_count !== 16'd0) begin n_bad++; $display("FAIL rst_dec_count: got %0d want 0", dec_count); end
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_k      = 6'h3F;
      out_ready = 1'b1;
      step();
      step();
      n_tot += 3;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL uncfg_in_ready: got %b want 0", in_ready); end
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL uncfg_out_valid: got %b want 0", out_valid); end
      if (dec_count !== 16'd0) begin n_bad++; $display("FAIL uncfg_dec_count: got %0d want 0", dec_count); end
      in_valid = 1'b0;
   endtask

   task automatic test_or();
      logic [M-1:0] rows [6];
      rows = '{7'b0000010, 7'b0000101, 7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000};
      for (int i = 0; i < 6; i++) cfg_write(3'(i), rows[i]);
      commit(1'b0);
      push(6'b000010);
      n_tot += 2;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL or_valid: got %b want 1", out_valid); end
      if (out_y !== 7'b0000101) begin n_bad++; $display("FAIL or_y0: got %b want 0000101", out_y); end
      push(6'b100001);
      n_tot += 2;
      if (out_y !== 7'b1000010) begin n_bad++; $display("FAIL or_y1: got %b want 1000010", out_y); end
      if (dec_count !== 16'(exp_cnt)) begin n_bad++; $display("FAIL or_count: got %0d want %0d", dec_count, exp_cnt); end
      step();
      n_tot += 2;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL or_drain_valid: got %b want 0", out_valid); end
      if (out_y !== 7'b1000010) begin n_bad++; $display("FAIL or_hold_y: got %b want 1000010", out_y); end
   endtask

   task automatic test_xor();
      cfg_write(3'd0, 7'b0000011);
      cfg_write(3'd1, 7'b0000011);
      commit(1'b1);
      push(6'b000011);
      n_tot++;
      if (out_y !== 7'b0000000) begin n_bad++; $display("FAIL xor_cancel: got %b want 0000000", out_y); end
      push(6'b000000);
      n_tot++;
      if (out_y !== 7'b0000000) begin n_bad++; $display("FAIL xor_zero_k: got %b want 0000000", out_y); end
      commit(1'b0);
      push(6'b000011);
      n_tot++;
      if (out_y !== 7'b0000011) begin n_bad++; $display("FAIL or_same: got %b want 0000011", out_y); end
   endtask

   task automatic test_backpressure();
      logic [K-1:0] ks [4];
      logic [M-1:0] ys [4];
      ks = '{6'b001000, 6'b010000, 6'b100000, 6'b000001};
      ys = '{7'b0010000, 7'b0100000, 7'b1000000, 7'b0000011};
      out_ready = 1'b1;
      step();
      in_k      = 6'b000100;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      n_tot++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
      step();
      exp_cnt++;
      in_k = 6'b001000;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_tot += 4;
         if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready c%0d: got %b want 0", c, in_ready); end
         if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid c%0d: got %b want 1", c, out_valid); end
         if (out_y !== 7'b0001000) begin n_bad++; $display("FAIL bp_y c%0d: got %b want 0001000", c, out_y); end
         if (dec_count !== 16'(exp_cnt)) begin n_bad++; $display("FAIL bp_count c%0d: got %0d want %0d", c, dec_count, exp_cnt); end
         step();
      end
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         in_k = ks[j];
         #1;
         n_tot++;
         if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready j%0d: got %b want 1", j, in_ready); end
         step();
         exp_cnt++;
         n_tot++;
         if (out_y !== ys[j]) begin n_bad++; $display("FAIL b2b_y j%0d: got %b want %b", j, out_y, ys[j]); end
      end
      in_valid = 1'b0;
      step();
      n_tot += 2;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
      if (dec_count !== 16'(exp_cnt)) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", dec_count, exp_cnt); end
   endtask

   task automatic test_commit_drain();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_k      = 6'b000100;
      step();
      exp_cnt++;
      in_valid = 1'b0;
      cfg_write(3'd2, 7'b1111111);
      cfg_commit = 1'b1;
      cfg_xor    = 1'b0;
      step();
      cfg_commit = 1'b0;
      cfg_xor    = 1'b1;
      in_valid   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tot += 4;
         if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy c%0d: got %b want 1", c, cfg_busy); end
         if (in_ready !== 1'b0) begin n_bad++; $display("FAIL drain_ready c%0d: got %b want 0", c, in_ready); end
         if (out_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid c%0d: got %b want 1", c, out_valid); end
         if (out_y !== 7'b0001000) begin n_bad++; $display("FAIL drain_old_y c%0d: got %b want 0001000", c, out_y); end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_tot++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL drain_ready_rel: got %b want 0", in_ready); end
      step();
      n_tot += 4;
      if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL copy_busy: got %b want 1", cfg_busy); end
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL copy_ready: got %b want 0", in_ready); end
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL copy_valid: got %b want 0", out_valid); end
      if (out_y !== 7'b0001000) begin n_bad++; $display("FAIL copy_hold_y: got %b want 0001000", out_y); end
      cfg_we     = 1'b1;
      cfg_row    = 3'd3;
      cfg_data   = 7'b1111111;
      cfg_commit = 1'b1;
      step();
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      n_tot += 2;
      if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL one_copy_busy: got %b want 0", cfg_busy); end
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL run_ready: got %b want 1", in_ready); end
      step();
      exp_cnt++;
      n_tot++;
      if (out_y !== 7'b1111111) begin n_bad++; $display("FAIL new_h_y: got %b want 1111111", out_y); end
      in_k = 6'b001000;
      step();
      exp_cnt++;
      n_tot++;
      if (out_y !== 7'b0010000) begin n_bad++; $display("FAIL copy_write_y: got %b want 0010000", out_y); end
      in_k = 6'b000110;
      step();
      exp_cnt++;
      n_tot++;
      if (out_y !== 7'b1111111) begin n_bad++; $display("FAIL pend_xor_y: got %b want 1111111", out_y); end
      in_valid = 1'b0;
      step();
      n_tot++;
      if (dec_count !== 16'(exp_cnt)) begin n_bad++; $display("FAIL drain_count: got %0d want %0d", dec_count, exp_cnt); end
   endtask

   task automatic test_cfg_err();
      n_tot++;
      if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %b want 0", cfg_err); end
      cfg_write(3'd6, 7'b0011100);
      n_tot++;
      if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", cfg_err); end
      cfg_write(3'd1, 7'b0000011);
      step();
      commit(1'b1);
      push(6'b111111);
      n_tot += 2;
      if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", cfg_err); end
      if (out_y !== 7'b1100000) begin n_bad++; $display("FAIL err_bank_y: got %b want 1100000", out_y); end
   endtask

   task automatic test_rst_midstream();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_k      = 6'b000001;
      step();
      in_valid = 1'b0;
      n_tot++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
      rst = 1'b1;
      step();
      n_tot += 5;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mrst_ready: got %b want 0", in_ready); end
      if (dec_count !== 16'd0) begin n_bad++; $display("FAIL mrst_count: got %0d want 0", dec_count); end
      if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL mrst_err: got %b want 0", cfg_err); end
      if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b want 0", cfg_busy); end
      rst     = 1'b0;
      exp_cnt = 0;
      step();
      commit(1'b0);
      push(6'b111111);
      n_tot += 3;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL zero_h_valid: got %b want 1", out_valid); end
      if (out_y !== 7'b0000000) begin n_bad++; $display("FAIL zero_h_y: got %b want 0000000", out_y); end
      if (dec_count !== 16'd1) begin n_bad++; $display("FAIL zero_h_count: got %0d want 1", dec_count); end
   endtask

   task automatic test_count();
      int stalls;
      stalls    = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 999; i++) begin
         in_k = 6'(i);
         #1;
         if (!in_ready) stalls++;
         step();
      end
      in_valid = 1'b0;
      step();
      n_tot += 2;
      if (stalls != 0) begin n_bad++; $display("FAIL count_stalls: got %0d want 0", stalls); end
      if (dec_count !== 16'd1000) begin n_bad++; $display("FAIL count_1000: got %0d want 1000", dec_count); end
   endtask

   initial begin
      rst        = 1'b1;
      cfg_we     = 1'b0;
      cfg_row    = '0;
      cfg_data   = '0;
      cfg_xor    = 1'b0;
      cfg_commit = 1'b0;
      in_valid   = 1'b0;
      in_k       = '0;
      out_ready  = 1'b0;
      test_reset();
      test_or();
      test_xor();
      test_backpressure();
      test_commit_drain();
      test_cfg_err();
      test_rst_midstream();
      test_count();
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
